stack_controller: RTL

Push/pop engine that drives the CPU's 32-entry word stack memory. It accepts push and pop commands from the execute stage over a valid/ready handshake and owns the stack pointer (`esp`). It issues single-cycle write strobes and addresses to the stack memory, samples its read port, and returns pop data or an error status over a second valid/ready handshake.

---
 rtl/stack_controller_if.sv | 32 +++
 rtl/stack_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/stack_controller_if.sv
// Command, response and stack-memory signals of the stack controller, bundled
// so the execute stage, the memory and the controller share one port.
interface stack_controller_if;
    logic        cmd_valid;
    logic        cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_ready;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_ready;

    logic [31:0] mem_esp;
    logic [3:0]  mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Controller side: accepts commands, returns responses, drives the memory.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, resp_ready, mem_rdata,
        output cmd_ready, resp_valid, resp_data, resp_err,
        output mem_esp, mem_rw, mem_wdata
    );

    // Environment side: execute stage plus stack memory.
    modport master (
        output cmd_valid, cmd_op, cmd_data, resp_ready, mem_rdata,
        input  cmd_ready, resp_valid, resp_data, resp_err,
        input  mem_esp, mem_rw, mem_wdata
    );
endinterface

// File: rtl/stack_controller.sv
// Push/pop engine for the downward-growing word stack: owns esp, issues
// one-cycle write strobes, samples the combinational read port, returns status.
module stack_controller #(
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    stack_controller_if.slave        bus,
    output logic [31:0]              sp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] wdata_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        do_push;
    logic        do_err;

    assign count = CW'(DEPTH_W - sp);
    assign full  = (sp == 32'd0);
    assign empty = (sp == DEPTH_W);

    assign bus.mem_esp   = sp;
    assign bus.mem_wdata = wdata_q;
    assign bus.resp_data = resp_data_q;
    assign bus.resp_err  = resp_err_q;

    always_comb begin
        state_nxt      = state;
        bus.cmd_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_rw     = 4'h0;
        do_push        = 1'b0;
        do_err         = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_op && !full) begin
                        do_push   = 1'b1;
                        state_nxt = WRITE;
                    end else if (!bus.cmd_op && !empty) begin
                        state_nxt = READ;
                    end else begin
                        // Overflow or underflow: answer at once, leave memory alone.
                        do_err    = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            WRITE: begin
                bus.mem_rw = 4'h1;
                state_nxt  = RESP;
            end
            READ: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sp          <= DEPTH_W;
            wdata_q     <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (do_push) begin
                        // Pre-decrement so WRITE addresses the new top slot.
                        sp      <= sp - 32'd1;
                        wdata_q <= bus.cmd_data;
                    end
                    if (do_err) begin
                        resp_data_q <= 32'd0;
                        resp_err_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    resp_data_q <= 32'd0;
                    resp_err_q  <= 1'b0;
                end
                READ: begin
                    resp_data_q <= bus.mem_rdata;
                    resp_err_q  <= 1'b0;
                    sp          <= sp + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
